// File: rtl/tri_pixel_scanner.sv
// Rasterizer front end: latches one triangle, clips its bounding box to the screen and emits
// pixel centres in raster order. Define TRI_SCANNER_PERF_COUNT_EN to build the pixel counter.
module tri_pixel_scanner #(
  parameter int unsigned XWIDTH     = 24,
  parameter int unsigned YWIDTH     = 24,
  parameter int unsigned FRAC       = 14,
  parameter int unsigned VAL_WIDTH  = 16,
  parameter int unsigned AINV_WIDTH = 16,
  parameter int unsigned HRES       = 320,
  parameter int unsigned VRES       = 180,
  parameter int unsigned HWIDTH     = 9,
  parameter int unsigned VWIDTH     = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      freeze,
  input  logic                      tri_valid_in,
  output logic                      tri_ready_out,
  input  logic [3*XWIDTH-1:0]       x_tri_in,
  input  logic [3*YWIDTH-1:0]       y_tri_in,
  input  logic [AINV_WIDTH-1:0]     iarea_in,
  input  logic [3*VAL_WIDTH-1:0]    vals_in,
  output logic [XWIDTH-1:0]         x_out,
  output logic [YWIDTH-1:0]         y_out,
  output logic [HWIDTH-1:0]         hcount_out,
  output logic [VWIDTH-1:0]         vcount_out,
  output logic [3*XWIDTH-1:0]       x_tri_out,
  output logic [3*YWIDTH-1:0]       y_tri_out,
  output logic [AINV_WIDTH-1:0]     iarea_out,
  output logic [3*VAL_WIDTH-1:0]    vals_out,
  output logic                      pixel_valid_out,
  output logic                      last_out,
  output logic                      busy_out,
  output logic [31:0]               pix_count_out
);

  // Floor values carry one extra bit so signed clip compares cannot overflow.
  localparam int unsigned XFW = XWIDTH - FRAC + 1;
  localparam int unsigned YFW = YWIDTH - FRAC + 1;
  localparam logic signed [XFW-1:0] XLIM  = XFW'(HRES - 1);
  localparam logic signed [YFW-1:0] YLIM  = YFW'(VRES - 1);
  localparam logic [XWIDTH-1:0]     XHALF = XWIDTH'(1) << (FRAC - 1);
  localparam logic [YWIDTH-1:0]     YHALF = YWIDTH'(1) << (FRAC - 1);

  typedef enum logic [1:0] {StIdle, StBbox, StClip, StScan} state_e;

  state_e state_q, state_d;

  logic [3*XWIDTH-1:0]    x_tri_q;
  logic [3*YWIDTH-1:0]    y_tri_q;
  logic [AINV_WIDTH-1:0]  iarea_q;
  logic [3*VAL_WIDTH-1:0] vals_q;

  logic signed [XFW-1:0] xlo_q, xhi_q, xlo_d, xhi_d, xmin_c, xmax_c;
  logic signed [YFW-1:0] ylo_q, yhi_q, ylo_d, yhi_d, ymin_c, ymax_c;
  logic [HWIDTH-1:0]     xmin_q, xmax_q, hcount_q, hcount_d;
  logic [VWIDTH-1:0]     ymin_q, ymax_q, vcount_q, vcount_d;
  logic [XWIDTH-1:0]     x_q, x_d;
  logic [YWIDTH-1:0]     y_q, y_d;

  logic signed [XWIDTH-1:0] xa, xb, xc, xmn, xmx;
  logic signed [YWIDTH-1:0] ya, yb, yc, ymn, ymx;

  logic accept, box_empty, pix_last, cnt_ld;

  assign xa = x_tri_q[0 +: XWIDTH];
  assign xb = x_tri_q[XWIDTH +: XWIDTH];
  assign xc = x_tri_q[2*XWIDTH +: XWIDTH];
  assign ya = y_tri_q[0 +: YWIDTH];
  assign yb = y_tri_q[YWIDTH +: YWIDTH];
  assign yc = y_tri_q[2*YWIDTH +: YWIDTH];

  always_comb begin
    xmn = xa;
    xmx = xa;
    if (xb < xmn) xmn = xb;
    if (xc < xmn) xmn = xc;
    if (xb > xmx) xmx = xb;
    if (xc > xmx) xmx = xc;
    ymn = ya;
    ymx = ya;
    if (yb < ymn) ymn = yb;
    if (yc < ymn) ymn = yc;
    if (yb > ymx) ymx = yb;
    if (yc > ymx) ymx = yc;
    xlo_d = XFW'(xmn >>> FRAC);
    xhi_d = XFW'(xmx >>> FRAC);
    ylo_d = YFW'(ymn >>> FRAC);
    yhi_d = YFW'(ymx >>> FRAC);
  end

  always_comb begin
    xmin_c    = xlo_q[XFW-1] ? '0 : xlo_q;
    xmax_c    = (xhi_q > XLIM) ? XLIM : xhi_q;
    ymin_c    = ylo_q[YFW-1] ? '0 : ylo_q;
    ymax_c    = (yhi_q > YLIM) ? YLIM : yhi_q;
    box_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);
  end

  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    cnt_ld        = 1'b0;
    tri_ready_out = (state_q == StIdle) && !freeze;
    accept        = tri_ready_out && tri_valid_in;
    pix_last      = (state_q == StScan) && (hcount_q == xmax_q) && (vcount_q == ymax_q);
    unique case (state_q)
      StIdle: if (accept) state_d = StBbox;
      StBbox: state_d = StClip;
      StClip: begin
        if (box_empty) begin
          state_d = StIdle;
        end else begin
          state_d  = StScan;
          hcount_d = HWIDTH'(xmin_c);
          vcount_d = VWIDTH'(ymin_c);
          cnt_ld   = 1'b1;
        end
      end
      StScan: begin
        if (pix_last) begin
          state_d = StIdle;
        end else begin
          cnt_ld = 1'b1;
          if (hcount_q < xmax_q) begin
            hcount_d = hcount_q + HWIDTH'(1);
          end else begin
            hcount_d = xmin_q;
            vcount_d = vcount_q + VWIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    x_d = (XWIDTH'(hcount_d) << FRAC) | XHALF;
    y_d = (YWIDTH'(vcount_d) << FRAC) | YHALF;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      x_tri_q  <= '0;
      y_tri_q  <= '0;
      iarea_q  <= '0;
      vals_q   <= '0;
      xlo_q    <= '0;
      xhi_q    <= '0;
      ylo_q    <= '0;
      yhi_q    <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (!freeze) begin
      state_q <= state_d;
      if (accept) begin
        x_tri_q <= x_tri_in;
        y_tri_q <= y_tri_in;
        iarea_q <= iarea_in;
        vals_q  <= vals_in;
      end
      if (state_q == StBbox) begin
        xlo_q <= xlo_d;
        xhi_q <= xhi_d;
        ylo_q <= ylo_d;
        yhi_q <= yhi_d;
      end
      if (state_q == StClip) begin
        xmin_q <= HWIDTH'(xmin_c);
        xmax_q <= HWIDTH'(xmax_c);
        ymin_q <= VWIDTH'(ymin_c);
        ymax_q <= VWIDTH'(ymax_c);
      end
      // Counters only move while a pixel is pending, so coordinates track hcount/vcount.
      if (cnt_ld) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        x_q      <= x_d;
        y_q      <= y_d;
      end
    end
  end

`ifdef TRI_SCANNER_PERF_COUNT_EN
  logic [31:0] pix_count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pix_count_q <= '0;
    end else if (!freeze && (state_q == StScan)) begin
      pix_count_q <= pix_count_q + 32'd1;
    end
  end

  assign pix_count_out = pix_count_q;
`else
  assign pix_count_out = '0;
`endif

  assign pixel_valid_out = (state_q == StScan);
  assign last_out        = pix_last;
  assign busy_out        = (state_q != StIdle);
  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign x_out           = x_q;
  assign y_out           = y_q;
  assign x_tri_out       = x_tri_q;
  assign y_tri_out       = y_tri_q;
  assign iarea_out       = iarea_q;
  assign vals_out        = vals_q;

endmodule

// File: tb/tb_tri_pixel_scanner.sv
// Directed bench for tri_pixel_scanner: raster order, clipping, empty boxes, freeze and reset.
module tb_tri_pixel_scanner;

  localparam int XW = 24;
  localparam int YW = 24;
  localparam int FR = 14;
  localparam int VLW = 16;
  localparam int AW = 16;
  localparam int HW = 9;
  localparam int VCW = 8;

  logic            clk_in = 1'b0;
  logic            rst_in, freeze, tri_valid_in, tri_ready_out;
  logic [3*XW-1:0] x_tri_in, x_tri_out;
  logic [3*YW-1:0] y_tri_in, y_tri_out;
  logic [AW-1:0]   iarea_in, iarea_out;
  logic [3*VLW-1:0] vals_in, vals_out;
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_out;
  logic [HW-1:0]   hcount_out;
  logic [VCW-1:0]  vcount_out;
  logic            pixel_valid_out, last_out, busy_out;
  logic [31:0]     pix_count_out;

  int n_checks = 0;
  int n_errors = 0;

  tri_pixel_scanner dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .freeze          (freeze),
    .tri_valid_in    (tri_valid_in),
    .tri_ready_out   (tri_ready_out),
    .x_tri_in        (x_tri_in),
    .y_tri_in        (y_tri_in),
    .iarea_in        (iarea_in),
    .vals_in         (vals_in),
    .x_out           (x_out),
    .y_out           (y_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .x_tri_out       (x_tri_out),
    .y_tri_out       (y_tri_out),
    .iarea_out       (iarea_out),
    .vals_out        (vals_out),
    .pixel_valid_out (pixel_valid_out),
    .last_out        (last_out),
    .busy_out        (busy_out),
    .pix_count_out   (pix_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Coordinates are raw fixed-point integers (value * 2^14).
  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int tag);
    logic [3*XW-1:0]  xe;
    logic [3*YW-1:0]  ye;
    logic [AW-1:0]    ae;
    logic [3*VLW-1:0] ve;
    int waited;
    xe = {XW'(x2), XW'(x1), XW'(x0)};
    ye = {YW'(y2), YW'(y1), YW'(y0)};
    ae = AW'(32'h1000 + tag);
    ve = {VLW'(tag * 3), VLW'(tag * 2), VLW'(tag)};
    x_tri_in     = xe;
    y_tri_in     = ye;
    iarea_in     = ae;
    vals_in      = ve;
    tri_valid_in = 1'b1;
    waited = 0;
    while (!tri_ready_out && waited < 20) begin
      step();
      waited++;
    end
    check("ready_wait", 64'(tri_ready_out), 64'd1);
    step();
    tri_valid_in = 1'b0;
    x_tri_in     = '0;
    y_tri_in     = '0;
    check("x_tri_hi", 64'(x_tri_out[71:36]), 64'(xe[71:36]));
    check("x_tri_lo", 64'(x_tri_out[35:0]), 64'(xe[35:0]));
    check("y_tri_hi", 64'(y_tri_out[71:36]), 64'(ye[71:36]));
    check("y_tri_lo", 64'(y_tri_out[35:0]), 64'(ye[35:0]));
    check("iarea_vals", 64'({iarea_out, vals_out}), 64'({ae, ve}));
  endtask

  // Called right after the handshake edge; walks the expected clipped box.
  task automatic scan_box(input int xmin, input int xmax, input int ymin, input int ymax,
                          input int fh, input int fv);
    logic [19:0] pexp;
    logic [47:0] cexp;
    check("bbox_state", 64'({busy_out, pixel_valid_out}), 64'(2'b10));
    step();
    check("clip_state", 64'({busy_out, pixel_valid_out}), 64'(2'b10));
    step();
    for (int v = ymin; v <= ymax; v++) begin
      for (int h = xmin; h <= xmax; h++) begin
        pexp = {1'b1, (h == xmax && v == ymax), HW'(h), VCW'(v)};
        cexp = {XW'((h << FR) + (1 << (FR - 1))), YW'((v << FR) + (1 << (FR - 1)))};
        check("pix", 64'({pixel_valid_out, last_out, hcount_out, vcount_out}), 64'(pexp));
        check("centre", 64'({x_out, y_out}), 64'(cexp));
        if (h == fh && v == fv) begin
          freeze = 1'b1;
          for (int k = 0; k < 5; k++) begin
            step();
            check("frz_pix", 64'({pixel_valid_out, last_out, hcount_out, vcount_out}),
                  64'(pexp));
            check("frz_rdy", 64'(tri_ready_out), 64'd0);
          end
          freeze = 1'b0;
        end
        step();
      end
    end
    check("scan_done", 64'({pixel_valid_out, busy_out, tri_ready_out}), 64'(3'b001));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    freeze = 1'b0;
    tri_valid_in = 1'b0;
    x_tri_in = '0;
    y_tri_in = '0;
    iarea_in = '0;
    vals_in = '0;
    step();
    step();
    rst_in = 1'b0;
    check("rst_flags", 64'({pixel_valid_out, last_out, busy_out, tri_ready_out}), 64'(4'b0001));
    check("rst_coord", 64'({x_out, y_out, hcount_out, vcount_out}), 64'd0);
    check("rst_tri", 64'(x_tri_out[63:0] | y_tri_out[63:0]), 64'd0);
    check("rst_count", 64'(pix_count_out), 64'd0);

    // (2,3),(5.5,3),(2,4.9): 4x2 box at (2..5, 3..4)
    send_tri(32768, 49152, 90112, 49152, 32768, 80282, 1);
    scan_box(2, 5, 3, 4, -1, -1);

    // Partly off-screen: clips to 0..3 x 0..1
    send_tri(-163840, -163840, 49152, -163840, 49152, 16384, 2);
    scan_box(0, 3, 0, 1, -1, -1);

    // Fully off-screen to the right: no pixels, ready at cycle 3
    send_tri(6553600, 163840, 6717440, 163840, 6635520, 327680, 3);
    check("empty_bbox", 64'({busy_out, pixel_valid_out}), 64'(2'b10));
    step();
    check("empty_clip", 64'({busy_out, pixel_valid_out}), 64'(2'b10));
    step();
    check("empty_done", 64'({tri_ready_out, busy_out, pixel_valid_out}), 64'(3'b100));

    // Freeze for five cycles on pixel (3,3) of a 2..5 x 2..4 box
    send_tri(32768, 32768, 90112, 32768, 32768, 73728, 4);
    scan_box(2, 5, 2, 4, 3, 3);

    // Reset in the middle of a scan abandons the triangle
    send_tri(32768, 49152, 90112, 49152, 32768, 80282, 5);
    step();
    step();
    step();
    check("mid_scan", 64'({pixel_valid_out, hcount_out, vcount_out}),
          64'({1'b1, HW'(3), VCW'(3)}));
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("rst_scan", 64'({pixel_valid_out, busy_out, tri_ready_out}), 64'(3'b001));
    check("rst_scan_hv", 64'({hcount_out, vcount_out, x_out}), 64'd0);
    check("rst_scan_tri", 64'(x_tri_out[63:0]), 64'd0);
    check("rst_scan_cnt", 64'(pix_count_out), 64'd0);

    // Back-to-back 8- and 6-pixel triangles after reset
    send_tri(-163840, -163840, 49152, -163840, 49152, 16384, 6);
    scan_box(0, 3, 0, 1, -1, -1);
    send_tri(0, 0, 40960, 0, 0, 24576, 7);
    scan_box(0, 2, 0, 1, -1, -1);
`ifdef TRI_SCANNER_PERF_COUNT_EN
    check("pix_count", 64'(pix_count_out), 64'd14);
`else
    check("pix_count", 64'(pix_count_out), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
